// File: rtl/noc_rr_arbiter_pkg.sv
// Shared NoC packet layout: {dest_addr, payload} as used by PEs and switches.
package noc_rr_arbiter_pkg;

  localparam int NocAddressWidth = 3;
  localparam int NocDataWidth    = 32;
  localparam int NocTotalWidth   = NocAddressWidth + NocDataWidth;

  // Field offsets inside a packet: dest at [NocDestLsb +: NocAddressWidth],
  // payload at [NocDataWidth-1:0].
  localparam int NocDestLsb      = NocDataWidth;
  localparam int NocPayloadLsb   = 0;

  // Width of the back-pressure statistics counter.
  localparam int NocBusyCntWidth = 32;

endpackage

// File: rtl/noc_rr_arbiter_rr_priority_picker.sv
// Combinational rotating-priority picker: first set request at or after ptr,
// wrapping modulo numInputs.
module rr_priority_picker #(
  parameter int numInputs    = 4,
  parameter int InputIdWidth = 2
) (
  input  logic [numInputs-1:0]    req_i,
  input  logic [InputIdWidth-1:0] ptr_i,
  output logic [numInputs-1:0]    grant_oh_o,
  output logic [InputIdWidth-1:0] grant_idx_o,
  output logic                    any_o
);

  // Walk the requests in priority order starting at ptr; first hit wins.
  always_comb begin
    logic                    found;
    logic [InputIdWidth:0]   sum;
    logic [InputIdWidth-1:0] idx;
    grant_oh_o  = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    sum         = '0;
    idx         = '0;
    for (int off = 0; off < numInputs; off++) begin
      sum = {1'b0, ptr_i} + (InputIdWidth + 1)'(off);
      if (sum >= (InputIdWidth + 1)'(numInputs)) begin
        sum = sum - (InputIdWidth + 1)'(numInputs);
      end
      idx = sum[InputIdWidth-1:0];
      if (!found && req_i[idx]) begin
        found           = 1'b1;
        grant_oh_o[idx] = 1'b1;
        grant_idx_o     = idx;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/noc_rr_arbiter.sv
// Round-robin arbiter merging numInputs valid/ready packet streams onto one
// registered output link, with a back-pressure cycle counter.
module noc_rr_arbiter
  import noc_rr_arbiter_pkg::*;
#(
  parameter int numInputs    = 4,
  parameter int InputIdWidth = 2,
  parameter int AddressWidth = NocAddressWidth,
  parameter int DataWidth    = NocDataWidth,
  parameter int TotalWidth   = NocTotalWidth
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [numInputs*TotalWidth-1:0] i_data,
  input  logic [numInputs-1:0]            i_data_valid,
  output logic [numInputs-1:0]            o_data_ready,
  output logic [TotalWidth-1:0]           o_data,
  output logic                            o_data_valid,
  input  logic                            i_data_ready,
  output logic [InputIdWidth-1:0]         o_grant_id,
  output logic [NocBusyCntWidth-1:0]      o_busy_cnt
);

  // Elaboration-time parameter sanity checks.
  if (numInputs < 2) begin : g_bad_num_inputs
    $error("noc_rr_arbiter: numInputs must be >= 2");
  end
  if (TotalWidth != AddressWidth + DataWidth) begin : g_bad_total_width
    $error("noc_rr_arbiter: TotalWidth must equal AddressWidth + DataWidth");
  end
  if (InputIdWidth < $clog2(numInputs)) begin : g_bad_id_width
    $error("noc_rr_arbiter: InputIdWidth too narrow for numInputs");
  end

  function automatic logic [NocBusyCntWidth-1:0] sat_inc(
    input logic [NocBusyCntWidth-1:0] v
  );
    return (v == '1) ? v : v + NocBusyCntWidth'(1);
  endfunction

  logic [InputIdWidth-1:0]    ptr_q, ptr_d;
  logic [TotalWidth-1:0]      data_q, data_d;
  logic [InputIdWidth-1:0]    gid_q, gid_d;
  logic                       valid_q, valid_d;
  logic [NocBusyCntWidth-1:0] busy_q, busy_d;

  logic [numInputs-1:0]       grant_oh;
  logic [InputIdWidth-1:0]    grant_idx;
  logic                       req_any;
  logic                       load_en;
  logic                       xfer;
  logic [TotalWidth-1:0]      sel_pkt;

  rr_priority_picker #(
    .numInputs   (numInputs),
    .InputIdWidth(InputIdWidth)
  ) u_picker (
    .req_i      (i_data_valid),
    .ptr_i      (ptr_q),
    .grant_oh_o (grant_oh),
    .grant_idx_o(grant_idx),
    .any_o      (req_any)
  );

  // Output register can accept when empty or when drained this same cycle.
  assign load_en = ~valid_q | i_data_ready;
  assign xfer    = load_en & req_any & ~rst;

  assign o_data_ready = grant_oh & {numInputs{xfer}};

  // One-hot mux of the winning source's packet.
  always_comb begin
    sel_pkt = '0;
    for (int k = 0; k < numInputs; k++) begin
      if (grant_oh[k]) begin
        sel_pkt = i_data[k*TotalWidth +: TotalWidth];
      end
    end
  end

  // Next state of the output stage, priority pointer and stall counter.
  always_comb begin
    ptr_d   = ptr_q;
    data_d  = data_q;
    gid_d   = gid_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    if (valid_q && !i_data_ready) begin
      busy_d = sat_inc(busy_q);
    end
    if (xfer) begin
      data_d  = sel_pkt;
      gid_d   = grant_idx;
      valid_d = 1'b1;
      ptr_d   = (grant_idx == InputIdWidth'(numInputs - 1)) ?
                '0 : grant_idx + InputIdWidth'(1);
    end else if (load_en) begin
      valid_d = 1'b0;
    end
  end

  // State registers; reset empties the output stage and rewinds priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      data_q  <= '0;
      gid_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= '0;
    end else begin
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      gid_q   <= gid_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign o_data       = data_q;
  assign o_data_valid = valid_q;
  assign o_grant_id   = gid_q;
  assign o_busy_cnt   = busy_q;

endmodule

// File: tb/tb_noc_rr_arbiter.sv
// Self-checking bench for noc_rr_arbiter: directed phases plus a random soak,
// compared against a cycle-level behavioural model and a delivery scoreboard.
module tb_noc_rr_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int AW = 3;
  localparam int DW = 32;
  localparam int TW = 35;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*TW-1:0] i_data;
  logic [N-1:0]    i_data_valid;
  logic [N-1:0]    o_data_ready;
  logic [TW-1:0]   o_data;
  logic            o_data_valid;
  logic            i_data_ready;
  logic [IW-1:0]   o_grant_id;
  logic [31:0]     o_busy_cnt;

  noc_rr_arbiter #(
    .numInputs   (N),
    .InputIdWidth(IW),
    .AddressWidth(AW),
    .DataWidth   (DW),
    .TotalWidth  (TW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_data      (i_data),
    .i_data_valid(i_data_valid),
    .o_data_ready(o_data_ready),
    .o_data      (o_data),
    .o_data_valid(o_data_valid),
    .i_data_ready(i_data_ready),
    .o_grant_id  (o_grant_id),
    .o_busy_cnt  (o_busy_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Source side: pending packets per port, and whether the port is presenting.
  logic [TW-1:0] src_q[N][$];
  bit            src_on[N];
  int            wait_cnt[N];

  // Behavioural model of the arbiter.
  bit            m_valid;
  logic [TW-1:0] m_data;
  int            m_gid;
  int            m_ptr;
  logic [31:0]   m_busy;

  // Soak scoreboard.
  bit            soak;
  int            rcv_cnt;
  int            rcv_seq[N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Spec rule: first valid index scanning from p upward, modulo N.
  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int o = 0; o < N; o++) begin
      if (v[(p + o) % N]) return (p + o) % N;
    end
    return -1;
  endfunction

  function automatic logic [TW-1:0] mk_pkt(input int k, input int payload);
    logic [TW-1:0] p;
    p = {AW'(k), DW'(payload)};
    return p;
  endfunction

  task automatic cycle(input bit r, input bit rdy);
    logic [N-1:0]  exp_rdy;
    logic [N-1:0]  dut_rdy;
    logic [TW-1:0] dd;
    logic [TW-1:0] gpkt;
    bit            dv;
    bit            le;
    int            g;
    int            s;
    // present sources
    for (int k = 0; k < N; k++) begin
      if (!src_on[k] && src_q[k].size() > 0) begin
        src_on[k] = soak ? ($urandom_range(0, 1) == 1) : 1'b1;
      end
    end
    rst          = r;
    i_data_ready = rdy;
    for (int k = 0; k < N; k++) begin
      i_data_valid[k]        = src_on[k];
      i_data[k*TW +: TW]     = src_on[k] ? src_q[k][0] : '0;
    end
    @(negedge clk);
    le      = !m_valid || rdy;
    g       = pick(i_data_valid, m_ptr);
    exp_rdy = '0;
    if (!r && le && g >= 0) exp_rdy[g] = 1'b1;
    chk("o_data_ready", 64'(o_data_ready), 64'(exp_rdy));
    dut_rdy = o_data_ready;
    dv      = o_data_valid;
    dd      = o_data;
    gpkt    = (g >= 0) ? i_data[g*TW +: TW] : '0;
    @(posedge clk);
    // model update
    if (r) begin
      m_valid = 1'b0; m_data = '0; m_gid = 0; m_ptr = 0; m_busy = '0;
    end else begin
      if (m_valid && !rdy && m_busy != 32'hFFFF_FFFF) m_busy = m_busy + 1;
      if (le && g >= 0) begin
        m_data = gpkt; m_gid = g; m_valid = 1'b1; m_ptr = (g + 1) % N;
      end else if (le) begin
        m_valid = 1'b0;
      end
    end
    // downstream delivery scoreboard
    if (soak && !r && dv && rdy) begin
      s = int'(dd[DW +: AW]);
      if (s < N) begin
        chk("src_order", 64'(dd[15:0]), 64'(rcv_seq[s]));
        rcv_seq[s]++;
      end
      rcv_cnt++;
    end
    // source handshakes and fairness bound
    for (int k = 0; k < N; k++) begin
      if (dut_rdy[k] && src_on[k]) begin
        for (int o = 0; o < N; o++) begin
          if (o != k && src_on[o]) wait_cnt[o]++;
        end
        chk("max_wait", 64'(wait_cnt[k] <= N - 1), 64'd1);
        wait_cnt[k] = 0;
        void'(src_q[k].pop_front());
        src_on[k] = 1'b0;
      end
    end
    #1;
    chk("o_data_valid", 64'(o_data_valid), 64'(m_valid));
    chk("o_data", 64'(o_data), 64'(m_data));
    chk("o_grant_id", 64'(o_grant_id), 64'(m_gid));
    chk("o_busy_cnt", 64'(o_busy_cnt), 64'(m_busy));
    if (o_data_valid === 1'b1) chk("gid_vs_dest", 64'(o_grant_id), 64'(o_data[DW +: AW]));
  endtask

  initial begin
    logic [31:0] busy_before;
    int          guard;
    rst = 1'b1; i_data_ready = 1'b0; i_data = '0; i_data_valid = '0;
    soak = 1'b0; rcv_cnt = 0;
    m_valid = 1'b0; m_data = '0; m_gid = 0; m_ptr = 0; m_busy = '0;
    for (int k = 0; k < N; k++) begin
      src_on[k] = 1'b0; wait_cnt[k] = 0; rcv_seq[k] = 0;
    end

    // Reset with all sources valid, then full contention.
    for (int k = 0; k < N; k++)
      for (int n = 0; n < 6; n++) src_q[k].push_back(mk_pkt(k, k * 100 + n));
    repeat (3) cycle(1'b1, 1'b1);
    chk("reset_valid", 64'(o_data_valid), 64'd0);
    chk("reset_busy", 64'(o_busy_cnt), 64'd0);
    repeat (26) cycle(1'b0, 1'b1);

    // Single requester on port 2, then port 3 to wrap the pointer.
    for (int n = 0; n < 10; n++) src_q[2].push_back(mk_pkt(2, 200 + n));
    repeat (10) cycle(1'b0, 1'b1);
    src_q[3].push_back(mk_pkt(3, 333));
    repeat (2) cycle(1'b0, 1'b1);
    for (int k = 0; k < N; k++) src_q[k].push_back(mk_pkt(k, 400 + k));
    repeat (6) cycle(1'b0, 1'b1);

    // Back-pressure with ports 1 and 3 waiting.
    src_q[0].push_back(mk_pkt(0, 500));
    cycle(1'b0, 1'b1);
    busy_before = o_busy_cnt;
    src_q[1].push_back(mk_pkt(1, 501));
    src_q[3].push_back(mk_pkt(3, 503));
    repeat (5) cycle(1'b0, 1'b0);
    chk("busy_plus5", 64'(o_busy_cnt - busy_before), 64'd5);
    repeat (4) cycle(1'b0, 1'b1);

    // Reset while the output register holds 0x1_0000_0007.
    src_q[1].push_back({3'd1, 32'h0000_0007});
    cycle(1'b0, 1'b0);
    chk("held_pkt", 64'(o_data), 64'h1_0000_0007);
    src_q[2].push_back(mk_pkt(2, 777));
    cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    chk("midreset_valid", 64'(o_data_valid), 64'd0);
    repeat (4) cycle(1'b0, 1'b1);

    // Random soak: 100 packets per source, random downstream ready.
    soak = 1'b1;
    for (int k = 0; k < N; k++) begin
      rcv_seq[k] = 0; wait_cnt[k] = 0;
      for (int n = 0; n < 100; n++) src_q[k].push_back(mk_pkt(k, n));
    end
    guard = 0;
    while (rcv_cnt < 4 * 100 && guard < 6000) begin
      cycle(1'b0, $urandom_range(0, 3) != 0);
      guard++;
    end
    repeat (3) cycle(1'b0, 1'b1);
    chk("soak_count", 64'(rcv_cnt), 64'd400);
    for (int k = 0; k < N; k++) chk("soak_src_done", 64'(rcv_seq[k]), 64'd100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
